// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   UART_DATA_BITS  : payload bits per frame
//   uart_rx_state_t : receiver FSM states
//   even_parity     : parity helper used by the optional 8E1 check
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  // The even-parity bit is the XOR of the payload: it makes the total number
  // of ones in payload plus parity bit even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/data_sync.sv
// -----------------------------------------------------------------------------
// data_sync
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so the same cell can be used for idle-high and idle-low lines.
// Ports:
//   clk_i   in  destination clock
//   rst_i   in  asynchronous active-high reset (both flops load RESET_VAL)
//   async_i in  asynchronous input
//   sync_o  out synchronized output, two clocks behind async_i
// -----------------------------------------------------------------------------
module data_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; the second gives it a full cycle to settle
  // before anything downstream looks at the value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= async_i;
      r_sync <= r_meta;
    end
  end

  assign sync_o = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// UART receive deserializer. Recovers 8-bit LSB-first frames from the
// asynchronous serial line and holds each byte on a level valid/ready
// handshake until the consumer accepts it.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> 8E1 frames, parity error raises frame_err
//                      undefined -> 8N1 frames, no parity state or logic
//
// Parameters:
//   CLK_FREQ   clock frequency in Hz
//   BAUD_RATE  line bit rate; DIV = CLK_FREQ / BAUD_RATE must be >= 4
// Ports:
//   clk_i                in  system clock
//   rst_i                in  asynchronous active-high reset
//   uart_rx_i            in  serial line, idles high, asynchronous
//   uart_rx_data_rdy_i   in  consumer accepts the held byte while high
//   uart_rx_data_o       out received byte, stable while valid is high
//   uart_rx_data_vld_o   out byte available (level)
//   uart_rx_frame_err_o  out one-cycle pulse: bad stop/parity, byte dropped
//   uart_rx_overrun_o    out one-cycle pulse: byte completed while valid high
// -----------------------------------------------------------------------------
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  input  logic       uart_rx_data_rdy_i,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_rx_data_vld_o,
  output logic       uart_rx_frame_err_o,
  output logic       uart_rx_overrun_o
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  // Strobe lands in the middle of each bit, measured from the start-bit edge.
  localparam logic [CNT_W-1:0] CNT_STROBE = CNT_W'(DIV / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(UART_DATA_BITS - 1);

  logic                       w_rx_s;
  uart_rx_state_t             r_state;
  uart_rx_state_t             w_state_next;
  logic [CNT_W-1:0]           r_bit_cnt;
  logic                       w_strobe;
  logic [UART_DATA_BITS-1:0]  r_shreg;
  logic [IDX_W-1:0]           r_idx;
  logic                       w_par_ok;
  logic                       w_clr_timer;
  logic                       w_shift;
  logic                       w_frame_done;
  logic                       w_frame_bad;
  logic                       w_vld_kept;

  logic [7:0]                 r_data;
  logic                       r_vld;
  logic                       r_frame_err;
  logic                       r_overrun;

  // Bring the serial line into the clock domain; idle level is high so the
  // synchronizer comes out of reset looking like an idle line.
  data_sync #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (uart_rx_i),
    .sync_o  (w_rx_s)
  );

  assign w_strobe = (r_bit_cnt == CNT_STROBE);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. WAIT_IDLE keeps a held-low line (break) from being
  // read as an endless stream of start bits after a framing error.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) w_state_next = START;
      end
      START: begin
        if (w_strobe) w_state_next = w_rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (w_strobe && (r_idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_strobe) w_state_next = STOP;
      end
`endif
      STOP: begin
        if (w_strobe) w_state_next = (w_rx_s && w_par_ok) ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (w_rx_s) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic w_par_capture;
  logic r_par_ok;
`endif

  // Output decode of the FSM: per-cycle control strobes for the datapath.
  always_comb begin
    w_clr_timer  = 1'b0;
    w_shift      = 1'b0;
    w_frame_done = 1'b0;
    w_frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_capture = 1'b0;
`endif
    case (r_state)
      IDLE:    w_clr_timer = ~w_rx_s;
      DATA:    w_shift     = w_strobe;
`ifdef UART_RX_PARITY_EN
      PARITY:  w_par_capture = w_strobe;
`endif
      STOP: begin
        if (w_strobe) begin
          w_frame_done = w_rx_s & w_par_ok;
          w_frame_bad  = ~(w_rx_s & w_par_ok);
        end
      end
      default: ;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict is captured mid parity bit and consumed at the stop strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_par_ok <= 1'b1;
    end else if (w_par_capture) begin
      r_par_ok <= (w_rx_s == even_parity(r_shreg));
    end
  end

  assign w_par_ok = r_par_ok;
`else
  assign w_par_ok = 1'b1;
`endif

  // Bit timer, restarted on the start-bit edge so that every strobe lands
  // half a bit period after the corresponding bit boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bit_cnt <= '0;
    end else if (w_clr_timer || (r_bit_cnt == CNT_LAST)) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  // Payload shift register. Bits arrive LSB first, so each new bit enters at
  // the top and after eight shifts bit 0 sits at shreg[0].
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (w_clr_timer) begin
      r_idx   <= '0;
    end else if (w_shift) begin
      r_shreg <= {w_rx_s, r_shreg[UART_DATA_BITS-1:1]};
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

  // Handshake side: an acceptance in this cycle frees the holding register
  // before a completing frame is considered, so accept-and-complete in the
  // same cycle loads the new byte rather than flagging an overrun.
  assign w_vld_kept = r_vld & ~uart_rx_data_rdy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data      <= 8'h00;
      r_vld       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= w_frame_done & w_vld_kept;
      if (w_frame_done && !w_vld_kept) begin
        r_data <= r_shreg;
        r_vld  <= 1'b1;
      end else begin
        r_vld  <= w_vld_kept;
      end
    end
  end

  assign uart_rx_data_o      = r_data;
  assign uart_rx_data_vld_o  = r_vld;
  assign uart_rx_frame_err_o = r_frame_err;
  assign uart_rx_overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 1_000_000;
  localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;

  typedef enum int {EV_BYTE = 0, EV_ERR = 1, EV_OVR = 2} evKind_t;
  typedef struct {
    evKind_t    kind;
    logic [7:0] data;
  } evItem_t;

  logic       clk;
  logic       rst;
  logic       rxPin;
  logic       rdy;
  logic [7:0] dataOut;
  logic       vld;
  logic       frameErr;
  logic       overrun;

  evItem_t    expQ[$];
  int         assertCount;
  int         failCount;
  int         cycleCount;
  int         lastStartCycle;
  int         lastRiseCycle;
  int         lastFallCycle;
  logic       prevVld;

  uart_rx_frame #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .uart_rx_i           (rxPin),
    .uart_rx_data_rdy_i  (rdy),
    .uart_rx_data_o      (dataOut),
    .uart_rx_data_vld_o  (vld),
    .uart_rx_frame_err_o (frameErr),
    .uart_rx_overrun_o   (overrun)
  );

  // 50 MHz clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Free-running cycle counter used for latency measurements.
  initial begin
    cycleCount = 0;
    forever begin
      @(posedge clk);
      cycleCount = cycleCount + 1;
    end
  end

  // Hard stop in case something wedges the stimulus.
  initial begin
    #(20 * 60000);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: bump the counters and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount = assertCount + 1;
    if (actual !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Match an observed DUT event against the head of the expectation queue.
  task automatic handleEvent(input evKind_t kind, input logic [7:0] data);
    evItem_t exp;
    if (expQ.size() == 0) begin
      assertCount = assertCount + 1;
      failCount   = failCount + 1;
      $display("[TB] FAIL unexpectedEvent: got kind %0d data 0x%0h, expected none",
               int'(kind), data);
    end else begin
      exp = expQ.pop_front();
      checkOutput("eventKind", 32'(int'(kind)), 32'(int'(exp.kind)));
      if (exp.kind != EV_ERR) checkOutput("eventData", 32'(data), 32'(exp.data));
    end
  endtask

  // Monitor: samples on the falling edge and reports valid rises, error and
  // overrun pulses to the scoreboard.
  initial begin
    prevVld       = 1'b0;
    lastRiseCycle = 0;
    lastFallCycle = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevVld = vld;
      end else begin
        if (vld && !prevVld) begin
          lastRiseCycle = cycleCount;
          handleEvent(EV_BYTE, dataOut);
        end
        if (!vld && prevVld) lastFallCycle = cycleCount;
        if (frameErr) handleEvent(EV_ERR, dataOut);
        if (overrun) handleEvent(EV_OVR, dataOut);
        prevVld = vld;
      end
    end
  end

  task automatic sendBit(input logic b);
    rxPin = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Drive one complete frame; parityBad inverts the parity bit when the
  // parity build is in use.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input logic parityBad);
    lastStartCycle = cycleCount;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
`ifdef UART_RX_PARITY_EN
    sendBit((^data) ^ parityBad);
`else
    if (parityBad) $display("[TB] parity flip ignored in 8N1 build");
`endif
    sendBit(stopBit);
  endtask

  task automatic waitDrain(input int limit);
    for (int i = 0; i < limit && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("queueDrain", 32'(expQ.size()), 32'd0);
  endtask

  function automatic evItem_t mkEv(input evKind_t kind, input logic [7:0] data);
    evItem_t e;
    e.kind = kind;
    e.data = data;
    return e;
  endfunction

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst   = 1'b1;
    rxPin = 1'b1;
    rdy   = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("resetData", 32'(dataOut), 32'h00);
    checkOutput("resetVld", 32'(vld), 32'd0);
    checkOutput("resetFrameErr", 32'(frameErr), 32'd0);
    checkOutput("resetOverrun", 32'(overrun), 32'd0);
    repeat (10) @(negedge clk);

    // Single byte with ready tied high; latency from start edge to valid.
    $display("[TB] single byte 0x2A");
    expQ.push_back(mkEv(EV_BYTE, 8'h2A));
    applyStimulus(8'h2A, 1'b1, 1'b0);
    waitDrain(100);
    checkOutput("vldLatency", 32'(lastRiseCycle - lastStartCycle), 32'd478);
    checkOutput("vldWidthOk",
                32'((lastFallCycle - lastRiseCycle >= 1) && (lastFallCycle - lastRiseCycle <= 2)),
                32'd1);
    repeat (20) @(negedge clk);

    // Back-to-back frames with ready low: second one overruns.
    $display("[TB] back-to-back 0x2E, 0xA5 with ready low");
    rdy = 1'b0;
    expQ.push_back(mkEv(EV_BYTE, 8'h2E));
    expQ.push_back(mkEv(EV_OVR, 8'h2E));
    applyStimulus(8'h2E, 1'b1, 1'b0);
    applyStimulus(8'hA5, 1'b1, 1'b0);
    waitDrain(100);
    checkOutput("heldVld", 32'(vld), 32'd1);
    checkOutput("heldData", 32'(dataOut), 32'h2E);
    rdy = 1'b1;
    @(negedge clk);
    checkOutput("acceptLatency", 32'(vld), 32'd0);
    repeat (20) @(negedge clk);

    // Short low glitch must be rejected silently.
    $display("[TB] 20-clock glitch");
    rxPin = 1'b0;
    repeat (20) @(negedge clk);
    rxPin = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("glitchVld", 32'(vld), 32'd0);

    // Bad stop bit with the line held low for three bit-times, then recovery.
    $display("[TB] framing error 0x55 then 0x01");
    expQ.push_back(mkEv(EV_ERR, 8'h00));
    lastStartCycle = cycleCount;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(i[0] ? 1'b0 : 1'b1);
`ifdef UART_RX_PARITY_EN
    sendBit(1'b0);
`endif
    rxPin = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    rxPin = 1'b1;
    waitDrain(10);
    checkOutput("errNoVld", 32'(vld), 32'd0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    expQ.push_back(mkEv(EV_BYTE, 8'h01));
    applyStimulus(8'h01, 1'b1, 1'b0);
    waitDrain(100);
    repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Parity check: flipped parity bit is an error, correct one delivers.
    $display("[TB] parity 0x03");
    expQ.push_back(mkEv(EV_ERR, 8'h00));
    applyStimulus(8'h03, 1'b1, 1'b1);
    waitDrain(100);
    repeat (20) @(negedge clk);
    expQ.push_back(mkEv(EV_BYTE, 8'h03));
    applyStimulus(8'h03, 1'b1, 1'b0);
    waitDrain(100);
    repeat (20) @(negedge clk);
`endif

    // Reset mid-frame: a held byte and the partial frame both disappear.
    $display("[TB] reset during 0xFF");
    rdy = 1'b0;
    expQ.push_back(mkEv(EV_BYTE, 8'h7E));
    applyStimulus(8'h7E, 1'b1, 1'b0);
    waitDrain(100);
    checkOutput("preResetVld", 32'(vld), 32'd1);
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("inResetData", 32'(dataOut), 32'h00);
    checkOutput("inResetVld", 32'(vld), 32'd0);
    checkOutput("inResetFrameErr", 32'(frameErr), 32'd0);
    checkOutput("inResetOverrun", 32'(overrun), 32'd0);
    rdy = 1'b1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    expQ.push_back(mkEv(EV_BYTE, 8'h2B));
    applyStimulus(8'h2B, 1'b1, 1'b0);
    waitDrain(100);
    repeat (100) @(negedge clk);
    checkOutput("finalQueueEmpty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
